// File: rtl/pipeline_result_collector_pkg.sv
// Shared definitions for the pipeline result collector slice: collector
// FSM states, default widths tied to the 5-stage pipeline, and a small
// width helper used to size counters from their maximum value.
package pipeline_result_collector_pkg;

  // Result word width produced by the pipeline unit.
  localparam int PIPE_DATA_W       = 32;

  // Number of pipeline stages; results still in flight after a flush.
  localparam int PIPE_DEPTH_STAGES = 5;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } collector_state_t;

  // Bits needed to hold the value max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipeline_result_collector_sync_fwft_fifo.sv
// First-word-fall-through synchronous FIFO: head word is visible on
// rd_data without a read strobe. Occupancy is tracked in its own counter
// so full/empty never depend on pointer aliasing. clear empties the FIFO
// in one cycle and takes priority over push/pop.
module sync_fwft_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  // Guard the strobes locally so the occupancy can never wrap even if a
  // caller asserts pop while empty or push while full without a pop.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Storage write at the tail.
  // NOTE: the array has no reset on purpose; only pointers and count carry
  // meaning, so resetting data would cost a wide reset net for nothing.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Head word and status flags.
  always_comb begin
    rd_data = mem[rd_ptr];
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
  end

endmodule

// File: rtl/pipeline_result_collector.sv
// Collects every result word emitted by the 5-stage pipeline into a FWFT
// FIFO and hands them to the retire side over valid/ready. The pipeline
// cannot be stalled, so results arriving while the FIFO is full and not
// draining are dropped, counted and flagged. A flush empties the FIFO and
// then ignores the results still travelling down the pipeline for
// SQUASH_CYCLES cycles.
module pipeline_result_collector
  import pipeline_result_collector_pkg::*;
#(
  parameter int DATA_W        = PIPE_DATA_W,
  parameter int DEPTH         = 8,
  parameter int SQUASH_CYCLES = PIPE_DEPTH_STAGES,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   squashing,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int              SQ_W    = cnt_w(SQUASH_CYCLES);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES);
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(1);

  collector_state_t state_q, state_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic run_in;
  logic accept;
  logic drop;

  sync_fwft_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (accept),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Handshake and accept/drop decisions. A flush cycle hides the head so
  // the consumer never takes a word that is about to be discarded.
  always_comb begin
    out_valid = !fifo_empty && !flush;
    pop       = out_valid && out_ready;
    run_in    = in_valid && (state_q == RUN) && !flush;
    accept    = run_in && (!fifo_full || pop);
    drop      = run_in && fifo_full && !pop;
    full      = fifo_full;
    empty     = fifo_empty;
    squashing = (state_q == SQUASH);
  end

  // Squash FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  // Squash FSM next state: a flush (re)arms the window, which then counts
  // down one cycle per in-flight pipeline stage before returning to RUN.
  // NOTE: defaults first so every path assigns state_d/sq_cnt_d and no
  // latch is inferred.
  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    unique case (state_q)
      RUN: begin
        if (flush && (SQUASH_CYCLES > 0)) begin
          state_d  = SQUASH;
          sq_cnt_d = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (flush) begin
          sq_cnt_d = SQ_LOAD;
        end else if (sq_cnt_q <= SQ_LAST) begin
          state_d  = RUN;
          sq_cnt_d = '0;
        end else begin
          sq_cnt_d = sq_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = RUN;
        sq_cnt_d = '0;
      end
    endcase
  end

  // Drop bookkeeping: sticky overflow flag and a saturating drop counter.
  // Neither is touched by flush so lost results stay visible until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Self-checking bench for pipeline_result_collector: a constant vector
// table for the basic flow, hand-written corner sequences, and a long
// randomized run compared every cycle against a queue-based model.
module tb_pipeline_result_collector;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int SQ     = 5;
  localparam int DCW    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              squashing;
  logic              overflow;
  logic [DCW-1:0]    drop_count;

  always #5 clk = ~clk;

  pipeline_result_collector #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .SQUASH_CYCLES (SQ),
    .DROP_CNT_W    (DCW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .squashing  (squashing),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the FIFO as a queue, the squash window as cycles left.
  logic [DATA_W-1:0] mq[$];
  int                m_sq    = 0;
  bit                m_ovf   = 1'b0;
  int                m_drops = 0;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              rdy;
    logic              exp_ov;
    logic [DATA_W-1:0] exp_od;
    logic [3:0]        exp_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                       input logic fl, input logic rdy);
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
    #1;
  endtask

  task automatic check_model(input string tag);
    bit mv;
    mv = (mq.size() != 0) && !flush;
    check({tag, ".out_valid"}, out_valid, mv);
    if (mv) check({tag, ".out_data"}, out_data, mq[0]);
    check({tag, ".count"}, count, mq.size());
    check({tag, ".full"}, full, mq.size() == DEPTH);
    check({tag, ".empty"}, empty, mq.size() == 0);
    check({tag, ".squashing"}, squashing, m_sq > 0);
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".drop_count"}, drop_count, m_drops);
  endtask

  // Advance the model with the current inputs, then the DUT by one edge.
  task automatic tick();
    bit mpop;
    if (reset) begin
      mq.delete();
      m_sq    = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      mpop = (mq.size() != 0) && !flush && out_ready;
      if (mpop) void'(mq.pop_front());
      if (flush) begin
        mq.delete();
        m_sq = SQ;
      end else if (m_sq > 0) begin
        m_sq--;
      end else if (in_valid) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(in_data);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < (1 << DCW) - 1) m_drops++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input string tag, input logic r, input logic iv,
                     input logic [DATA_W-1:0] d, input logic fl, input logic rdy);
    drive(r, iv, d, fl, rdy);
    check_model(tag);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    // Basic flow: four results with the consumer always ready.
    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  4'd0};
    tbl[1] = '{1'b1, 32'h12, 1'b1, 1'b1, 32'h11, 4'd1};
    tbl[2] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h12, 4'd1};
    tbl[3] = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h14, 4'd1};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h18, 4'd1};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  4'd0};

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    tick();

    // Reset state.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.empty", empty, 1'b1);
    check("rst.full", full, 1'b0);
    check("rst.squashing", squashing, 1'b0);
    check("rst.overflow", overflow, 1'b0);
    check("rst.drop_count", drop_count, 0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, tbl[i].iv, tbl[i].d, 1'b0, tbl[i].rdy);
      check($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) check($sformatf("tbl%0d.out_data", i), out_data, tbl[i].exp_od);
      check($sformatf("tbl%0d.count", i), count, tbl[i].exp_cnt);
      check($sformatf("tbl%0d.drop_count", i), drop_count, 0);
      check_model($sformatf("tbl%0d", i));
      tick();
    end

    // Fill and overflow: ten pushes into eight entries, nothing drained.
    do_reset();
    for (int i = 0; i < 10; i++) cyc("fill", 1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("fill.full", full, 1'b1);
    check("fill.count", count, 8);
    check("fill.drop_count", drop_count, 2);
    check("fill.overflow", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check($sformatf("drain%0d.out_data", i), out_data, 32'h100 + i);
      check_model("drain");
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("drain.empty", empty, 1'b1);
    check("drain.overflow_sticky", overflow, 1'b1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) cyc("fill8", 1'b0, 1'b1, 32'h200 + i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h208 + i, 1'b0, 1'b1);
      check("fullpop.count", count, 8);
      check("fullpop.out_data", out_data, 32'h200 + i);
      check_model("fullpop");
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("fullpop.order", out_data, 32'h203 + i);
      check_model("fullpop_drain");
      tick();
    end
    check("fullpop.drop_count", drop_count, 0);

    // Flush with data buffered, then the squash window.
    do_reset();
    for (int i = 0; i < 3; i++) cyc("pre_flush", 1'b0, 1'b1, 32'h30 + i, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hAA, 1'b1, 1'b1);
    check("flush1.out_valid", out_valid, 1'b0);
    check_model("flush1");
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'hB0 + k, 1'b0, 1'b0);
      check("squash.count", count, 0);
      check("squash.squashing", squashing, 1'b1);
      check("squash.drop_count", drop_count, 0);
      check_model("squash");
      tick();
    end
    drive(1'b0, 1'b1, 32'h3C, 1'b0, 1'b0);
    check("post_squash.squashing", squashing, 1'b0);
    check_model("post_squash");
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("post_squash.count", count, 1);
    check("post_squash.out_data", out_data, 32'h3C);

    // Second flush two cycles into the squash window re-arms it.
    drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    check("flush2a.out_valid", out_valid, 1'b0);
    check_model("flush2a");
    tick();
    for (int k = 0; k < 2; k++) cyc("sq_a", 1'b0, 1'b1, 32'h50 + k, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h41, 1'b1, 1'b1);
    check("flush2b.out_valid", out_valid, 1'b0);
    check("flush2b.squashing", squashing, 1'b1);
    check_model("flush2b");
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h60 + k, 1'b0, 1'b1);
      check("resquash.squashing", squashing, 1'b1);
      check_model("resquash");
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("resquash.done", squashing, 1'b0);

    // Reset in the middle of a squash window after three drops.
    do_reset();
    for (int i = 0; i < 11; i++) cyc("fill11", 1'b0, 1'b1, 32'h70 + i, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("mid.drop_count", drop_count, 3);
    cyc("mid_flush", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) cyc("mid_sq", 1'b0, 1'b1, 32'h90 + k, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h99, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    check("midrst.squashing", squashing, 1'b0);
    check("midrst.count", count, 0);
    check("midrst.drop_count", drop_count, 0);
    check("midrst.overflow", overflow, 1'b0);
    check_model("midrst");
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("midrst.accept_count", count, 1);
    check("midrst.accept_data", out_data, 32'h55);

    // Randomized traffic against the model, biased toward a filling FIFO.
    for (int n = 0; n < 3000; n++) begin
      cyc("rand",
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom,
          $urandom_range(0, 23) == 0,
          $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
